// File: rtl/or1k_mul_pipelined_cappuccino.sv
// Three-stage pipelined 32x32 multiplier for the cappuccino pipeline.
// Operands are captured as magnitudes, multiplied as four half-width partial products, then summed and sign-corrected.
module or1k_mul_pipelined_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_i,
  input  logic                            flush_i,
  input  logic                            op_mul_i,
  input  logic                            op_mul_signed_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] a_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] b_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] mul_result_o,
  output logic                            mul_valid_o,
  output logic                            overflow_set_o,
  output logic                            carry_set_o,
  output logic                            busy_o
);

  localparam int W  = OPTION_OPERAND_WIDTH;
  localparam int H  = W / 2;
  localparam int W2 = 2 * W;

  logic         s1_valid, s1_signed, s1_neg;
  logic [W-1:0] s1_a, s1_b;

  logic         s2_valid, s2_signed, s2_neg;
  logic [W-1:0] s2_ll, s2_lh, s2_hl, s2_hh;

  logic          a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic [W-1:0]  pp_ll, pp_lh, pp_hl, pp_hh;
  logic [W2-1:0] mag, prod;
  logic          ov_next, cy_next;

  always_comb begin
    a_neg = op_mul_signed_i & a_i[W-1];
    b_neg = op_mul_signed_i & b_i[W-1];
    // The most-negative operand negates to itself, which is its correct unsigned magnitude.
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
  end

  always_comb begin
    pp_ll = W'(s1_a[H-1:0]) * W'(s1_b[H-1:0]);
    pp_lh = W'(s1_a[H-1:0]) * W'(s1_b[W-1:H]);
    pp_hl = W'(s1_a[W-1:H]) * W'(s1_b[H-1:0]);
    pp_hh = W'(s1_a[W-1:H]) * W'(s1_b[W-1:H]);
  end

  always_comb begin
    mag = W2'(s2_ll)
        + (W2'(s2_lh) << H)
        + (W2'(s2_hl) << H)
        + {s2_hh, {W{1'b0}}};
    prod    = s2_neg ? -mag : mag;
    ov_next = s2_valid & s2_signed &
              ~((&prod[W2-1:W-1]) | ~(|prod[W2-1:W-1]));
    cy_next = s2_valid & ~s2_signed & (|prod[W2-1:W]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid       <= 1'b0;
      s1_signed      <= 1'b0;
      s1_neg         <= 1'b0;
      s1_a           <= '0;
      s1_b           <= '0;
      s2_valid       <= 1'b0;
      s2_signed      <= 1'b0;
      s2_neg         <= 1'b0;
      s2_ll          <= '0;
      s2_lh          <= '0;
      s2_hl          <= '0;
      s2_hh          <= '0;
      mul_result_o   <= '0;
      mul_valid_o    <= 1'b0;
      overflow_set_o <= 1'b0;
      carry_set_o    <= 1'b0;
    end else if (flush_i) begin
      // Flags are cleared with the valid bits so they never outlive a result.
      s1_valid       <= 1'b0;
      s2_valid       <= 1'b0;
      mul_valid_o    <= 1'b0;
      overflow_set_o <= 1'b0;
      carry_set_o    <= 1'b0;
    end else if (padv_i) begin
      s1_valid       <= op_mul_i;
      s1_signed      <= op_mul_signed_i;
      s1_neg         <= a_neg ^ b_neg;
      s1_a           <= a_mag;
      s1_b           <= b_mag;
      s2_valid       <= s1_valid;
      s2_signed      <= s1_signed;
      s2_neg         <= s1_neg;
      s2_ll          <= pp_ll;
      s2_lh          <= pp_lh;
      s2_hl          <= pp_hl;
      s2_hh          <= pp_hh;
      mul_result_o   <= prod[W-1:0];
      mul_valid_o    <= s2_valid;
      overflow_set_o <= ov_next;
      carry_set_o    <= cy_next;
    end
  end

  assign busy_o = s1_valid | s2_valid | mul_valid_o;

endmodule
